// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that lets NREQ requesters share a single uart_tx.
// Grants one byte per frame and waits for the uart_tx busy handshake to complete.
module uart_tx_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                    CLOCK_TX,
    input  logic                    RESET,
    input  logic [NREQ-1:0]         REQ,
    input  logic [8*NREQ-1:0]       REQ_DATA,
    output logic [NREQ-1:0]         GNT,
    output logic                    SEND,
    output logic [7:0]              TX_DATA,
    input  logic                    NINTO,
    output logic                    BUSY,
    output logic [$clog2(NREQ)-1:0] LAST_GNT,
    output logic                    ERR
);

    localparam int unsigned IDX_W  = $clog2(NREQ);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic                send_q, send_d;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
    logic                busy_q, busy_d;
    logic [IDX_W-1:0]    last_gnt_q, last_gnt_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [BYTE_W-1:0]   req_byte [NREQ];
    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic [IDX_W-1:0]    cand;
    logic                grant_ok;
    logic                timed_out;

    // Split the flat data bus into one byte per requester.
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_byte[i] = REQ_DATA[BYTE_W*i +: BYTE_W];
        end
    end

    // Round-robin search starting just after the most recent winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IDX_W'((32'(last_gnt_q) + i) % NREQ);
            if (!win_found && REQ[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // uart_tx still reporting busy in IDLE means its previous frame has not ended.
    assign grant_ok  = win_found && !NINTO;
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT)) && !NINTO;

    // State register.
    always_ff @(posedge CLOCK_TX) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_ok) begin
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (NINTO) begin
                    state_d = ST_WAIT_DONE;
                end else if (timed_out) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!NINTO) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic; grant and start strobes default low so they last one cycle.
    always_comb begin
        gnt_d      = '0;
        send_d     = 1'b0;
        err_d      = 1'b0;
        tx_data_d  = tx_data_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        busy_d     = (state_d != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (grant_ok) begin
                    gnt_d      = NREQ'(1) << win_idx;
                    send_d     = 1'b1;
                    tx_data_d  = req_byte[win_idx];
                    last_gnt_d = win_idx;
                    cnt_d      = '0;
                end
            end
            ST_WAIT_BUSY: begin
                if (timed_out) begin
                    err_d = 1'b1;
                end else if (!NINTO && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Output and counter registers; a timed-out requester keeps LAST_GNT and loses its turn.
    always_ff @(posedge CLOCK_TX) begin
        if (RESET) begin
            gnt_q      <= '0;
            send_q     <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            last_gnt_q <= IDX_W'(NREQ - 1);
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            gnt_q      <= gnt_d;
            send_q     <= send_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            last_gnt_q <= last_gnt_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign GNT      = gnt_q;
    assign SEND     = send_q;
    assign TX_DATA  = tx_data_q;
    assign BUSY     = busy_q;
    assign LAST_GNT = last_gnt_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a grant scoreboard and a simple uart_tx busy model.
module tb_uart_tx_sched;

    localparam int FRAME = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  gnt;
    logic        send;
    logic [7:0]  tx_data;
    logic        ninto = 1'b0;
    logic        busy;
    logic [1:0]  last_gnt;
    logic        err;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q [$];
    int         checks = 0;
    int         errors = 0;
    int         send_cnt = 0;
    int         err_seen = 0;
    int         frame_cnt = 0;
    bit         auto_uart = 1'b0;
    logic [7:0] exp_tx = 8'h00;
    logic [1:0] exp_last = 2'd3;

    uart_tx_sched #(.NREQ(4), .TIMEOUT(15)) dut (
        .CLOCK_TX (clk),
        .RESET    (rst),
        .REQ      (req),
        .REQ_DATA (req_data),
        .GNT      (gnt),
        .SEND     (send),
        .TX_DATA  (tx_data),
        .NINTO    (ninto),
        .BUSY     (busy),
        .LAST_GNT (last_gnt),
        .ERR      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int idx, input logic [7:0] data);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // One clock: sample #1 after the edge, score grants, then advance the uart_tx model.
    task automatic cyc();
        logic rst_e;
        exp_t e;
        rst_e = rst;
        @(posedge clk);
        #1;
        if (rst_e) begin
            exp_tx   = 8'h00;
            exp_last = 2'd3;
        end else if (send === 1'b1) begin
            send_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_send", 32'(send), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("grant_onehot", 32'(gnt), 32'(1 << e.idx));
                exp_tx   = e.data;
                exp_last = 2'(e.idx);
            end
        end
        chk("tx_data", 32'(tx_data), 32'(exp_tx));
        chk("last_gnt", 32'(last_gnt), 32'(exp_last));
        chk("gnt_with_send", 32'(gnt != 4'b0), 32'(send));
        if (err === 1'b1) err_seen++;
        if (auto_uart) begin
            if (send === 1'b1) frame_cnt = FRAME;
            else if (frame_cnt > 0) frame_cnt--;
            ninto = (frame_cnt > 0);
        end
    endtask

    task automatic run_sends(input int n, input int budget);
        int start;
        int k;
        start = send_cnt;
        k = 0;
        while ((send_cnt - start) < n && k < budget) begin
            cyc();
            k++;
        end
        if ((send_cnt - start) < n) chk("send_timeout", 32'(send_cnt - start), 32'(n));
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin
            cyc();
            k++;
        end
        chk("idle_reached", 32'(busy), 32'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int k;

        // Reset values
        do_reset();
        chk("rst_gnt", 32'(gnt), 32'(0));
        chk("rst_send", 32'(send), 32'(0));
        chk("rst_tx", 32'(tx_data), 32'(8'h00));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_last", 32'(last_gnt), 32'(3));

        // Single requester 0 with byte A5
        auto_uart = 1'b1;
        req_data  = 32'h0000_00A5;
        req       = 4'b0001;
        push(0, 8'hA5);
        cyc();
        chk("t1_send", 32'(send), 32'(1));
        chk("t1_gnt", 32'(gnt), 32'(4'b0001));
        chk("t1_busy", 32'(busy), 32'(1));
        req = 4'b0000;
        cyc();
        chk("t1_send_low", 32'(send), 32'(0));
        chk("t1_gnt_low", 32'(gnt), 32'(0));
        chk("t1_busy_hold", 32'(busy), 32'(1));
        wait_idle(60);

        // All four requesting: strict rotation 0,1,2,3,0
        do_reset();
        req_data = 32'h4332_2110;
        req      = 4'b1111;
        push(0, 8'h10);
        push(1, 8'h21);
        push(2, 8'h32);
        push(3, 8'h43);
        push(0, 8'h10);
        run_sends(5, 200);
        req = 4'b0000;
        wait_idle(60);
        chk("t2_queue_empty", 32'(exp_q.size()), 32'(0));

        // Move pointer to 1, then 1001 wins 3 before 0
        req_data = 32'hD3C2_B1A0;
        req      = 4'b0010;
        push(1, 8'hB1);
        run_sends(1, 40);
        req = 4'b0000;
        wait_idle(60);
        req = 4'b1001;
        push(3, 8'hD3);
        push(0, 8'hA0);
        run_sends(2, 100);
        req = 4'b0000;
        wait_idle(60);

        // Handshake timeout: uart_tx never raises NINTO
        auto_uart = 1'b0;
        ninto     = 1'b0;
        req       = 4'b0100;
        req_data  = 32'h0077_0000;
        push(2, 8'h77);
        run_sends(1, 40);
        req = 4'b0000;
        k = 0;
        while (err !== 1'b1 && k < 40) begin
            cyc();
            k++;
        end
        chk("t4_err_latency", 32'(k), 32'(16));
        chk("t4_err", 32'(err), 32'(1));
        chk("t4_busy", 32'(busy), 32'(0));
        cyc();
        chk("t4_err_pulse", 32'(err), 32'(0));
        for (int i = 0; i < 4; i++) cyc();
        chk("t4_no_resend", 32'(send), 32'(0));

        // Reset during WAIT_DONE with NINTO high
        req_data = 32'h0000_005C;
        req      = 4'b0001;
        push(0, 8'h5C);
        run_sends(1, 40);
        req   = 4'b0000;
        ninto = 1'b1;
        cyc();
        chk("t5_busy_before", 32'(busy), 32'(1));
        rst = 1'b1;
        req = 4'b1111;
        cyc();
        chk("t5_busy", 32'(busy), 32'(0));
        chk("t5_tx", 32'(tx_data), 32'(8'h00));
        chk("t5_last", 32'(last_gnt), 32'(3));
        chk("t5_gnt", 32'(gnt), 32'(0));
        cyc();
        chk("t5_gnt_in_reset", 32'(gnt), 32'(0));
        chk("t5_send_in_reset", 32'(send), 32'(0));
        rst   = 1'b0;
        req   = 4'b0000;
        ninto = 1'b0;
        cyc();

        // NINTO high in IDLE blocks grants until it falls
        ninto    = 1'b1;
        req_data = 32'h0000_E100;
        req      = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t6_blocked", 32'(send), 32'(0));
        end
        push(1, 8'hE1);
        ninto = 1'b0;
        cyc();
        chk("t6_send", 32'(send), 32'(1));
        chk("t6_gnt", 32'(gnt), 32'(4'b0010));
        req   = 4'b0000;
        ninto = 1'b1;
        cyc();
        cyc();
        ninto = 1'b0;
        wait_idle(20);

        chk("final_queue_empty", 32'(exp_q.size()), 32'(0));
        chk("final_err_pulses", 32'(err_seen), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing one uart_tx; fixed at 4 in this revision.
REQ-002 Parameter: TIMEOUT, 15, maximum cycles to wait for NINTO to rise after SEND.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port: CLOCK_TX  input  1  system clock; all state changes on rising edge.
REQ-005 Port: RESET  input  1  synchronous, active-high reset.
REQ-006 Port: REQ  input  4  per-requester level request; held until granted.
REQ-007 Port: REQ_DATA  input  32  requester i byte on bits [8i+7:8i].
REQ-008 Port: GNT  output  4  one-hot, one-cycle grant pulse; requester may drop REQ or change data after it.
REQ-009 Port: SEND  output  1  one-cycle start pulse to uart_tx SEND.
REQ-010 Port: TX_DATA  output  8  byte to uart_tx TX_DATA; stable from SEND until the frame ends.
REQ-011 Port: NINTO  input  1  uart_tx busy flag; high while a frame is in progress.
REQ-012 Port: BUSY  output  1  high whenever state is not IDLE.
REQ-013 Port: LAST_GNT  output  2  index of most recently granted requester.
REQ-014 Port: ERR  output  1  one-cycle pulse on handshake timeout.

Function
REQ-015 FSM states SHALL be IDLE, WAIT_BUSY, WAIT_DONE; all outputs registered.
REQ-016 IDLE, any REQ bit high at edge: GNT[k], SEND, BUSY set to 1, TX_DATA loaded with requester k byte, LAST_GNT set to k, timeout counter cleared, state -> WAIT_BUSY.
REQ-017 Winner k SHALL be the first requester with REQ high, searching from (LAST_GNT+1) mod 4 upward with wrap (round-robin).
REQ-018 GNT and SEND SHALL be high for exactly one cycle, cleared on the next edge.
REQ-019 IDLE, REQ all zero: outputs hold, no state change.
REQ-020 WAIT_BUSY: NINTO high -> WAIT_DONE; otherwise counter increments by 1 (4-bit, saturates at 15).
REQ-021 WAIT_BUSY: counter equal to TIMEOUT with NINTO low -> ERR pulse 1 cycle, state -> IDLE, LAST_GNT retained (requester lost its slot; no retry).
REQ-022 WAIT_DONE: NINTO low -> state IDLE, BUSY cleared on the same edge; otherwise hold.
REQ-023 TX_DATA SHALL change only on a grant edge; never while in WAIT_BUSY or WAIT_DONE.
REQ-024 At least one IDLE cycle SHALL separate consecutive grants; minimum grant-to-grant spacing is frame length plus 3 cycles.
REQ-025 REQ changes while not IDLE SHALL be ignored; only REQ values sampled in IDLE count.
REQ-026 NINTO high while in IDLE SHALL block grants (uart_tx still busy); arbitration resumes the cycle after NINTO is low.
REQ-027 Single requester asserting continuously SHALL be granted once per frame with no starvation of others: each of 4 active requesters is granted within 4 frames.

Reset
REQ-028 RESET high at edge: state IDLE, GNT 0, SEND 0, TX_DATA 0x00, BUSY 0, ERR 0, LAST_GNT 3 (requester 0 has first priority), counter 0.
REQ-029 RESET mid-frame SHALL abort immediately to reset values regardless of NINTO; RESET has priority over all other inputs in that cycle.

Verification
REQ-030 After reset, REQ=0001, REQ_DATA[7:0]=0xA5 -> next edge GNT=0001, SEND=1, TX_DATA=0xA5, LAST_GNT=0; next cycle SEND=0; IDLE after NINTO falls.
REQ-031 REQ=1111 held with bytes 0x10,0x21,0x32,0x43 -> grants in order 0,1,2,3,0; TX_DATA sequence 0x10,0x21,0x32,0x43,0x10.
REQ-032 LAST_GNT=1, REQ=1001 -> GNT=1000 (requester 3), then requester 0 on the next grant.
REQ-033 Grant with NINTO held low -> after 15 cycles in WAIT_BUSY ERR=1 one cycle, state IDLE, BUSY=0, no second SEND.
REQ-034 RESET asserted during WAIT_DONE with NINTO=1 -> next edge BUSY=0, TX_DATA=0x00, LAST_GNT=3; no grant while RESET high.
REQ-035 NINTO forced high in IDLE with REQ=0010 -> no GNT/SEND until NINTO low; grant follows on the next edge.
